axi_isolate_drain: RTL

//  Handshake-level isolation unit for one AXI4 link: on isolate request it stops new AW/AR, drains

---
 rtl/axi_isolate_drain_if.sv | 39 +++
 rtl/axi_isolate_drain.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_isolate_drain_if.sv
// Handshake-level subset of an AXI4 link as seen by the isolation unit.
// Payload that bypasses the unit (addresses, W data, etc.) is not carried here.
interface axi_isolate_drain_if #(
   parameter int unsigned AXI_ID_WIDTH   = 10,
   parameter int unsigned AXI_DATA_WIDTH = 64
);
   logic                      aw_valid;
   logic                      aw_ready;
   logic [AXI_ID_WIDTH-1:0]   aw_id;
   logic                      ar_valid;
   logic                      ar_ready;
   logic [AXI_ID_WIDTH-1:0]   ar_id;
   logic [7:0]                ar_len;
   logic                      w_valid;
   logic                      w_ready;
   logic                      w_last;
   logic                      b_valid;
   logic                      b_ready;
   logic [AXI_ID_WIDTH-1:0]   b_id;
   logic [1:0]                b_resp;
   logic                      r_valid;
   logic                      r_ready;
   logic [AXI_ID_WIDTH-1:0]   r_id;
   logic [1:0]                r_resp;
   logic                      r_last;
   logic [AXI_DATA_WIDTH-1:0] r_data;

   modport master (
      output aw_valid, aw_id, ar_valid, ar_id, ar_len, w_valid, w_last, b_ready, r_ready,
      input  aw_ready, ar_ready, w_ready, b_valid, b_id, b_resp,
             r_valid, r_id, r_resp, r_last, r_data
   );

   modport slave (
      input  aw_valid, aw_id, ar_valid, ar_id, ar_len, w_valid, w_last, b_ready, r_ready,
      output aw_ready, ar_ready, w_ready, b_valid, b_id, b_resp,
             r_valid, r_id, r_resp, r_last, r_data
   );
endinterface

// File: rtl/axi_isolate_drain.sv
// AXI4 isolation unit: blocks new AW/AR on request, drains outstanding transactions,
// then reports isolated; optionally answers requests while isolated with DECERR.
module axi_isolate_drain #(
   parameter int unsigned AXI_ID_WIDTH   = 10,
   parameter int unsigned AXI_DATA_WIDTH = 64,
   parameter int unsigned MAX_TXNS       = 16,
   parameter bit          TERMINATE      = 1'b1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               isolate_i,
   output logic               isolated_o,
   axi_isolate_drain_if.slave  slv,
   axi_isolate_drain_if.master mst
);
   localparam int unsigned CW = $clog2(MAX_TXNS + 1);

   typedef enum logic [1:0] {StRun, StDrain, StIsolated} state_e;
   typedef enum logic [1:0] {WIdle, WData, WResp} wr_err_e;
   typedef enum logic {RIdle, RData} rd_err_e;

   state_e                  state_q, state_d;
   wr_err_e                 w_st_q, w_st_d;
   rd_err_e                 r_st_q, r_st_d;
   logic [CW-1:0]           wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
   logic                    aw_commit_q, aw_commit_d, ar_commit_q, ar_commit_d;
   logic                    isolated_q, isolated_d;
   logic [AXI_ID_WIDTH-1:0] w_id_q, w_id_d, r_id_q, r_id_d;
   logic [7:0]              r_len_q, r_len_d, r_beat_q, r_beat_d;

   logic aw_full, ar_full;
   logic aw_fwd, ar_fwd, aw_hs, ar_hs, b_hs, r_hs;

   assign aw_full    = (wr_cnt_q == CW'(MAX_TXNS));
   assign ar_full    = (rd_cnt_q == CW'(MAX_TXNS));
   assign isolated_o = isolated_q;

   always_comb begin
      // Pass-through defaults; payload fields follow their handshakes.
      mst.aw_id    = slv.aw_id;
      mst.ar_id    = slv.ar_id;
      mst.ar_len   = slv.ar_len;
      mst.w_valid  = slv.w_valid;
      mst.w_last   = slv.w_last;
      slv.w_ready  = mst.w_ready;
      slv.b_valid  = mst.b_valid;
      slv.b_id     = mst.b_id;
      slv.b_resp   = mst.b_resp;
      mst.b_ready  = slv.b_ready;
      slv.r_valid  = mst.r_valid;
      slv.r_id     = mst.r_id;
      slv.r_resp   = mst.r_resp;
      slv.r_last   = mst.r_last;
      slv.r_data   = mst.r_data;
      mst.r_ready  = slv.r_ready;
      aw_fwd       = 1'b0;
      ar_fwd       = 1'b0;
      slv.aw_ready = 1'b0;
      slv.ar_ready = 1'b0;
      state_d      = state_q;
      w_st_d       = w_st_q;
      r_st_d       = r_st_q;
      w_id_d       = w_id_q;
      r_id_d       = r_id_q;
      r_len_d      = r_len_q;
      r_beat_d     = r_beat_q;

      unique case (state_q)
         StRun: begin
            aw_fwd       = slv.aw_valid && !aw_full;
            slv.aw_ready = mst.aw_ready && !aw_full;
            ar_fwd       = slv.ar_valid && !ar_full;
            slv.ar_ready = mst.ar_ready && !ar_full;
         end
         StDrain: begin
            // Only a request already presented downstream may complete; never retract valid.
            aw_fwd       = slv.aw_valid && aw_commit_q;
            slv.aw_ready = mst.aw_ready && aw_commit_q;
            ar_fwd       = slv.ar_valid && ar_commit_q;
            slv.ar_ready = mst.ar_ready && ar_commit_q;
         end
         StIsolated: begin
            if (TERMINATE) begin
               slv.aw_ready = (w_st_q == WIdle);
               slv.ar_ready = (r_st_q == RIdle);
            end
         end
         default: ;
      endcase
      mst.aw_valid = aw_fwd;
      mst.ar_valid = ar_fwd;

      unique case (w_st_q)
         WIdle: begin
            if (TERMINATE && state_q == StIsolated && slv.aw_valid) begin
               w_id_d = slv.aw_id;
               w_st_d = WData;
            end
         end
         WData: begin
            slv.w_ready = 1'b1;
            mst.w_valid = 1'b0;
            if (slv.w_valid && slv.w_last) w_st_d = WResp;
         end
         WResp: begin
            slv.b_valid = 1'b1;
            slv.b_resp  = 2'b11;
            slv.b_id    = w_id_q;
            mst.b_ready = 1'b0;
            if (slv.b_ready) w_st_d = WIdle;
         end
         default: w_st_d = WIdle;
      endcase

      unique case (r_st_q)
         RIdle: begin
            if (TERMINATE && state_q == StIsolated && slv.ar_valid) begin
               r_id_d   = slv.ar_id;
               r_len_d  = slv.ar_len;
               r_beat_d = 8'd0;
               r_st_d   = RData;
            end
         end
         RData: begin
            slv.r_valid = 1'b1;
            slv.r_resp  = 2'b11;
            slv.r_id    = r_id_q;
            slv.r_last  = (r_beat_q == r_len_q);
            slv.r_data  = '0;
            mst.r_ready = 1'b0;
            if (slv.r_ready) begin
               if (r_beat_q == r_len_q) r_st_d = RIdle;
               else                     r_beat_d = r_beat_q + 8'd1;
            end
         end
         default: r_st_d = RIdle;
      endcase

      // Counts track only traffic that really crossed to/from the downstream side.
      aw_hs = aw_fwd && mst.aw_ready;
      ar_hs = ar_fwd && mst.ar_ready;
      b_hs  = mst.b_valid && mst.b_ready;
      r_hs  = mst.r_valid && mst.r_ready && mst.r_last;

      wr_cnt_d = wr_cnt_q;
      if (aw_hs && !b_hs)      wr_cnt_d = wr_cnt_q + CW'(1);
      else if (!aw_hs && b_hs) wr_cnt_d = wr_cnt_q - CW'(1);
      rd_cnt_d = rd_cnt_q;
      if (ar_hs && !r_hs)      rd_cnt_d = rd_cnt_q + CW'(1);
      else if (!ar_hs && r_hs) rd_cnt_d = rd_cnt_q - CW'(1);

      aw_commit_d = aw_fwd && !mst.aw_ready;
      ar_commit_d = ar_fwd && !mst.ar_ready;

      unique case (state_q)
         StRun: if (isolate_i) state_d = StDrain;
         StDrain: begin
            if (!isolate_i) begin
               state_d = StRun;
            end else if (wr_cnt_d == '0 && rd_cnt_d == '0 && !aw_commit_d && !ar_commit_d) begin
               state_d = StIsolated;
            end
         end
         StIsolated: begin
            // An error transaction accepted this cycle keeps the link isolated until it ends.
            if (!isolate_i && w_st_d == WIdle && r_st_d == RIdle) state_d = StRun;
         end
         default: state_d = StRun;
      endcase

      isolated_d = (state_q == StIsolated) && (state_d == StIsolated);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StRun;
         w_st_q      <= WIdle;
         r_st_q      <= RIdle;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         aw_commit_q <= 1'b0;
         ar_commit_q <= 1'b0;
         isolated_q  <= 1'b0;
         w_id_q      <= '0;
         r_id_q      <= '0;
         r_len_q     <= '0;
         r_beat_q    <= '0;
      end else begin
         state_q     <= state_d;
         w_st_q      <= w_st_d;
         r_st_q      <= r_st_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         aw_commit_q <= aw_commit_d;
         ar_commit_q <= ar_commit_d;
         isolated_q  <= isolated_d;
         w_id_q      <= w_id_d;
         r_id_q      <= r_id_d;
         r_len_q     <= r_len_d;
         r_beat_q    <= r_beat_d;
      end
   end
endmodule
